// File: rtl/sccb_pkg.sv
// sccb_pkg: shared SCCB state encoding, default device IDs and bit-counter width.
package sccb_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_ID_ACK, S_SUB, S_SUB_ACK, S_DATA, S_DATA_ACK, S_READ, S_READ_NA, S_IGNORE
  } state_t;
  localparam logic [7:0] SCCB_ID_WR = 8'h42;
  localparam logic [7:0] SCCB_ID_RD = 8'h43;
  localparam int CNT_W = 4;
endpackage

// File: rtl/sccb_line_sync.sv
// sccb_line_sync: 2-flop synchronizers plus edge and START/STOP detection on SIOC/SIOD.
module sccb_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic sioc,
  input  logic siod_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);
  logic [1:0] scl_sync_q, sda_sync_q;
  logic scl_p_q, sda_p_q, scl_s;
  // Idle bus is high on both lines, so reset to 1 to avoid phantom edges.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], sioc};
      sda_sync_q <= {sda_sync_q[0], siod_in};
      scl_p_q <= scl_sync_q[1];
      sda_p_q <= sda_sync_q[1];
    end
  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
  assign scl_rise = scl_s & ~scl_p_q;
  assign scl_fall = ~scl_s & scl_p_q;
  assign start_det = scl_s & scl_p_q & sda_p_q & ~sda_s;
  assign stop_det = scl_s & scl_p_q & ~sda_p_q & sda_s;
endmodule

// File: rtl/sccb_responder.sv
// sccb_responder: SCCB target decoding 3-phase write, 2-phase write and 2-phase read
// onto a simple register-bank port; SIOD is only ever pulled low.
import sccb_pkg::*;
module sccb_responder #(
  parameter logic [7:0] DEVICE_ID = SCCB_ID_WR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sioc,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       reg_wr,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       busy
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, addr_q, addr_d, wdata_q, wdata_d, rx_byte;
  logic oe_q, oe_d, wr_q, wr_d;
  logic scl_rise, scl_fall, start_det, stop_det, sda_s;
  sccb_line_sync u_sync (
    .clk(clk), .reset(reset), .sioc(sioc), .siod_in(siod_in),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det),
    .stop_det(stop_det), .sda_s(sda_s)
  );
  assign rx_byte = {sh_q[6:0], sda_s};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    oe_d = oe_q;
    wr_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    if (start_det) begin
      state_d = S_ID;
      cnt_d = '0;
      oe_d = 1'b0;
    end else if (stop_det) begin
      state_d = S_IDLE;
      cnt_d = '0;
      oe_d = 1'b0;
    end else case (state_q)
      S_ID, S_SUB, S_DATA: if (scl_rise) begin
        sh_d = rx_byte;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(7)) begin
          cnt_d = '0;
          if (state_q == S_ID)
            state_d = (rx_byte == DEVICE_ID || rx_byte == (DEVICE_ID | 8'h01)) ? S_ID_ACK : S_IGNORE;
          else if (state_q == S_SUB) begin
            state_d = S_SUB_ACK;
            addr_d = rx_byte;
          end else begin
            state_d = S_DATA_ACK;
            wr_d = 1'b1;
            wdata_d = rx_byte;
          end
        end
      end
      // First fall after the byte pulls SIOD low, the next one ends the ACK bit.
      S_ID_ACK, S_SUB_ACK, S_DATA_ACK: if (scl_fall) begin
        oe_d = ~oe_q;
        if (oe_q) begin
          state_d = state_q == S_ID_ACK ? (sh_q[0] ? S_READ : S_SUB) :
                    state_q == S_SUB_ACK ? S_DATA : S_IGNORE;
          if (state_q == S_ID_ACK && sh_q[0]) begin
            sh_d = reg_rdata;
            oe_d = ~reg_rdata[7];
          end
        end
      end
      S_READ: begin
        if (scl_rise) cnt_d = cnt_q + CNT_W'(1);
        if (scl_fall) begin
          if (cnt_q == CNT_W'(8)) begin
            state_d = S_READ_NA;
            oe_d = 1'b0;
          end else begin
            sh_d = {sh_q[6:0], 1'b0};
            oe_d = ~sh_q[6];
          end
        end
      end
      S_READ_NA: if (scl_rise) state_d = S_IGNORE;
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      oe_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      oe_q <= oe_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  assign siod_oe = oe_q;
  assign reg_wr = wr_q;
  assign reg_addr = addr_q;
  assign reg_wdata = wdata_q;
  assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_sccb_responder.sv
// tb_sccb_responder: SCCB master model driving the responder; writes and reads are
// checked against scoreboard queues filled when each transaction is issued.
module tb_sccb_responder;
  localparam int Q = 100;
  logic clk = 1'b0;
  logic reset, sioc, sda_m, siod_oe, reg_wr, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  wire siod_in = sda_m & ~siod_oe;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] wq[$];
  logic [7:0] rq[$];
  logic oe_seen;
  always #5 clk = ~clk;
  assign reg_rdata = reg_addr == 8'h0A ? 8'h76 : reg_addr ^ 8'h5A;
  sccb_responder dut (
    .clk(clk), .reset(reset), .sioc(sioc), .siod_in(siod_in), .siod_oe(siod_oe),
    .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (siod_oe) oe_seen = 1'b1;
    if (reg_wr) begin
      chk("wr_expected", 32'(wq.size() > 0), 32'd1);
      if (wq.size() > 0) chk("wr", {reg_addr, reg_wdata}, wq.pop_front());
    end
  end
  task automatic start_cond();
    sda_m = 1'b1; #Q; sioc = 1'b1; #Q; sda_m = 1'b0; #Q; sioc = 1'b0; #Q;
  endtask
  task automatic stop_cond();
    sda_m = 1'b0; #Q; sioc = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask
  task automatic send_bit(input logic b);
    sda_m = b; #Q; sioc = 1'b1; #(2 * Q); sioc = 1'b0; #Q;
  endtask
  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; #Q; sioc = 1'b1; #Q; ack = siod_oe; #Q; sioc = 1'b0; #Q;
  endtask
  task automatic read_byte(output logic [7:0] d, output logic na_oe);
    for (int i = 0; i < 8; i++) begin
      sda_m = 1'b1; #Q; sioc = 1'b1; #Q; d = {d[6:0], siod_in}; #Q; sioc = 1'b0; #Q;
    end
    sda_m = 1'b1; #Q; sioc = 1'b1; #Q; na_oe = siod_oe; #Q; sioc = 1'b0; #Q;
  endtask
  task automatic write3(input logic [7:0] a, input logic [7:0] d);
    logic ack;
    wq.push_back({a, d});
    start_cond();
    send_byte(8'h42, ack); chk("w3_id_ack", ack, 1);
    send_byte(a, ack); chk("w3_sub_ack", ack, 1);
    send_byte(d, ack); chk("w3_data_ack", ack, 1);
    stop_cond();
    chk("w3_busy_after_stop", busy, 0);
  endtask
  initial begin
    logic ack, na;
    logic [7:0] d;
    reset = 1'b1; sioc = 1'b1; sda_m = 1'b1; oe_seen = 1'b0;
    #21;
    chk("rst_oe", siod_oe, 0);
    chk("rst_wr", reg_wr, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_busy", busy, 0);
    #1 reset = 1'b0;
    #Q;
    write3(8'h12, 8'h80);
    chk("w3_addr_hold", reg_addr, 8'h12);
    chk("w3_wdata_hold", reg_wdata, 8'h80);
    // 2-phase write sets the address, then a 2-phase read returns it
    start_cond();
    chk("busy_after_start", busy, 1);
    send_byte(8'h42, ack); chk("p2_id_ack", ack, 1);
    send_byte(8'h0A, ack); chk("p2_sub_ack", ack, 1);
    stop_cond();
    chk("p2_addr", reg_addr, 8'h0A);
    rq.push_back(8'h76);
    start_cond();
    send_byte(8'h43, ack); chk("rd_id_ack", ack, 1);
    read_byte(d, na);
    chk("rd_data", d, rq.pop_front());
    chk("rd_na_oe", na, 0);
    stop_cond();
    chk("rd_busy", busy, 0);
    // wrong ID: never acknowledge, never write
    oe_seen = 1'b0;
    start_cond();
    send_byte(8'h60, ack); chk("bad_id_ack", ack, 0);
    send_byte(8'h12, ack); chk("bad_b1_ack", ack, 0);
    send_byte(8'h34, ack); chk("bad_b2_ack", ack, 0);
    chk("bad_busy", busy, 1);
    stop_cond();
    chk("bad_oe_seen", oe_seen, 0);
    // 4-byte write: only the first data byte lands
    wq.push_back(16'h3A04);
    start_cond();
    send_byte(8'h42, ack); chk("w4_id_ack", ack, 1);
    send_byte(8'h3A, ack); chk("w4_sub_ack", ack, 1);
    send_byte(8'h04, ack); chk("w4_data_ack", ack, 1);
    oe_seen = 1'b0;
    send_byte(8'hFF, ack); chk("w4_extra_ack", ack, 0);
    chk("w4_extra_oe_seen", oe_seen, 0);
    stop_cond();
    chk("w4_addr", reg_addr, 8'h3A);
    // repeated START in the middle of the SUB byte
    start_cond();
    send_byte(8'h42, ack); chk("rs_id_ack", ack, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    write3(8'h11, 8'h01);
    // reset while driving a read bit low
    start_cond();
    send_byte(8'h43, ack); chk("rr_id_ack", ack, 1);
    chk("rr_addr", reg_addr, 8'h11);
    sda_m = 1'b1; #Q; sioc = 1'b1; #Q;
    chk("rr_oe_before", siod_oe, reg_rdata[7] ? 0 : 1);
    reset = 1'b1;
    #1;
    chk("rr_oe_async", siod_oe, 0);
    chk("rr_busy_async", busy, 0);
    #20 reset = 1'b0;
    #Q;
    write3(8'h55, 8'hAA);
    #(4 * Q);
    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sccb_responder.md
# sccb_responder

SCCB target-side responder: the camera end of the SIOC/SIOD link. It decodes 3-phase write, 2-phase write and 2-phase read transactions from the configuration master and presents them on a simple register-bank port. The block emulates the OV7670 register interface in loopback benches and on-board self-tests. It drives SIOD only as an open-drain pull-down.

## Interface
- DEVICE_ID, 8'h42 — write slave ID; the read ID is DEVICE_ID|1.
- clk  in  1  system clock; must be ≥ 8× the SIOC frequency (25 MHz vs 100 kHz nominal).
- reset  in  1  asynchronous, active-high reset.
- sioc  in  1  SCCB clock from the master; asynchronous to clk.
- siod_in  in  1  sampled SIOD line level; asynchronous to clk.
- siod_oe  out  1  1 = pull SIOD low; 0 = release. The top level builds the tristate.
- reg_wr  out  1  one-cycle write strobe.
- reg_addr  out  8  current sub-address.
- reg_wdata  out  8  write data; valid while reg_wr = 1.
- reg_rdata  in  8  read data for reg_addr; combinational from the register bank.
- busy  out  1  high from START until STOP.

## Operation
- Line conditioning:
  - 2-flop synchronizer on sioc and siod_in, then a 1-flop edge detect.
  - START = SIOD falls while SIOC is high.
  - STOP = SIOD rises while SIOC is high.
  - Bits are sampled on SIOC rising edges and driven after SIOC falling edges.
- States:
  - IDLE
  - ID: shift 8 bits.
  - ID_ACK
  - SUB: shift 8 bits.
  - SUB_ACK
  - DATA: shift 8 bits.
  - DATA_ACK
  - READ: drive 8 bits.
  - READ_NA: master's NA bit.
  - IGNORE
- Transitions:
  - IDLE → ID on START.
  - ID complete:
    - byte = DEVICE_ID → ID_ACK → SUB.
    - byte = DEVICE_ID|1 → ID_ACK → READ.
    - any other byte → IGNORE. No ACK is driven.
  - SUB complete → latch reg_addr → SUB_ACK → DATA.
  - DATA complete → reg_wr pulses with reg_wdata → DATA_ACK → IGNORE.
  - Bytes after the DATA byte are not acknowledged and are not written. No auto-increment.
  - READ shifts out reg_rdata MSB first. reg_rdata is captured into the shift register on entry to READ.
  - READ → READ_NA. The NA bit value is ignored; READ_NA → IGNORE.
- Phase rules:
  - 2-phase write (ID, SUB, STOP) only updates reg_addr, with no reg_wr. It is used to set the address for a subsequent read.
  - ACK/don't-care bit: siod_oe = 1 for the whole 9th SIOC period of the ID, SUB and DATA phases when the byte was accepted.
- STOP in any state → IDLE, siod_oe = 0, busy = 0.
- START in any state (repeated start) → ID, with the bit counter cleared and siod_oe = 0.

## Timing
- Reset values:
  - siod_oe = 0, reg_wr = 0, reg_addr = 8'h00, reg_wdata = 8'h00, busy = 0.
  - State = IDLE, bit counter = 0.
- Reset mid-transaction releases SIOD immediately, as an asynchronous clear.
- Detection latency: 3 clk from a line edge (2 sync + 1 detect) to the internal event.
- The bit counter (0–8) increments on each detected SIOC rising edge.
- On the 8th rising edge, the byte decision is made in the same cycle.
- siod_oe timing:
  - Asserts on the clk after the SIOC falling edge that ends bit 8.
  - Releases on the clk after the next SIOC falling edge, which ends the 9th bit.
- Read bits:
  - siod_oe = ~shift[7] is updated one clk after each SIOC falling edge.
  - The first read bit is driven after the falling edge that ends the ID_ACK bit.
  - siod_oe = 0 during READ_NA.
- reg_wr:
  - Pulses exactly 1 clk, in the cycle after the 8th DATA bit is sampled.
  - reg_addr and reg_wdata are stable in that cycle and hold until the next write or address update.
- An SIOD change while SIOC is high inside a byte is treated as START/STOP, never as data.

## Structure
- Shared package sccb_pkg:
  - State encoding constants.
  - Default IDs: 8'h42/8'h43.
  - Bit-count width.
  - This package is shared with the master side.
- Sub-module sccb_line_sync: synchronizers plus rise/fall detection for both lines. Outputs scl_rise, scl_fall, start_det, stop_det and sda_s.

## Test plan
- 3-phase write 42/12/80 → reg_wr one pulse, reg_addr = 8'h12, reg_wdata = 8'h80. ACK (siod_oe = 1) in all three 9th bits.
- 2-phase write 42/0A, STOP, then 43 + read with reg_rdata = 8'h76:
  - SIOD bits 0,1,1,1,0,1,1,0 on the line.
  - No reg_wr at any point.
- Wrong ID 8'h60 followed by two bytes → no ACK, no reg_wr, and siod_oe stays 0 until STOP.
- 4-byte write 42/3A/04/FF → a single write of 8'h04 to 8'h3A, and the 4th byte is not acknowledged.
- Repeated START mid-SUB byte, then 42/11/01 → only the write of 8'h01 to 8'h11 occurs.
- Reset asserted during READ with siod_oe = 1 → siod_oe = 0 asynchronously, busy = 0. The next full transaction decodes normally.
